// File: rtl/uart_tx.sv
// uart_tx: serialises one byte per valid/ready handshake onto uart_txd (start, 8 data LSB first, optional parity, stop).
// Latency: start bit appears the cycle after accept; frame is 10*baud_cnt_max cycles (11* with UART_TX_PARITY_EN).
// Backpressure: tx_ready is low from accept until the cycle after the final stop-bit cycle; tx_valid is ignored meanwhile.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after data bit 7).
module uart_tx #(
    parameter int clk_freq     = 50000000,
    parameter int uart_bps     = 115200,
    // Clock cycles per bit; must lie in 2..65535.
    parameter int baud_cnt_max = clk_freq / uart_bps
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_txd,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Last count of a bit period, and the count one earlier: tx_done is
    // registered there so that it is visible during the final stop cycle.
    localparam logic [15:0] last_cnt = 16'(baud_cnt_max - 1);
    localparam logic [15:0] done_cnt = 16'(baud_cnt_max - 2);

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    assign bit_end = (baud_cnt == last_cnt);

    // Per-bit cycle counter: free-running while a frame is active, parked at 0 in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= 16'd0;
        end else if (state == S_IDLE || bit_end) begin
            baud_cnt <= 16'd0;
        end else begin
            baud_cnt <= baud_cnt + 16'd1;
        end
    end

    // Frame sequencer with registered line and handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'd0;
            uart_txd   <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    bit_cnt <= 3'd0;
                    if (tx_valid && tx_ready) begin
                        // Everything the frame needs is captured here, so later
                        // tx_data changes cannot disturb the frame in flight.
                        shift_reg  <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^tx_data;
`endif
                        state      <= S_START;
                        uart_txd   <= 1'b0;
                        tx_ready   <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        state    <= S_DATA;
                        bit_cnt  <= 3'd0;
                        uart_txd <= shift_reg[0];
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state    <= S_PARITY;
                            uart_txd <= parity_bit;
`else
                            state    <= S_STOP;
                            uart_txd <= 1'b1;
`endif
                        end else begin
                            // Line shows the bit that the shift is about to bring into bit 0.
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            uart_txd  <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state    <= S_STOP;
                        uart_txd <= 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (baud_cnt == done_cnt) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        // Stop bit is complete; ready reappears one cycle after tx_done,
                        // so a held tx_valid restarts without shortening the stop bit.
                        state    <= S_IDLE;
                        tx_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    uart_txd <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: default-rate instance plus a baud_cnt_max=4 instance.
// Expected line levels come from the frame rules: bit index = (cycle-1)/bit_width.
// Each task drives a scenario and checks inline.
module tb_uart_tx;

    localparam int B  = 434;
    localparam int SB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int  NBITS = 11;
    localparam bit  PAR   = 1'b1;
`else
    localparam int  NBITS = 10;
    localparam bit  PAR   = 1'b0;
`endif
    localparam int L  = NBITS * B;
    localparam int SL = NBITS * SB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic       tx_done;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       s_txd;
    logic       s_busy;
    logic       s_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .uart_txd (uart_txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    uart_tx #(.clk_freq(8), .uart_bps(2)) dut_s (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (s_data),
        .tx_valid (s_valid),
        .tx_ready (s_ready),
        .uart_txd (s_txd),
        .tx_busy  (s_busy),
        .tx_done  (s_done)
    );

    // Expected line level n cycles after the accept edge (n=1 is the first start-bit cycle).
    function automatic logic exp_line(input logic [7:0] b, input int n, input int bw);
        int idx;
        logic [7:0] v;
        v = b;
        if (n < 1) return 1'b1;
        idx = (n - 1) / bw;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return v[idx-1];
        if (PAR && idx == 9) return ^v;
        return 1'b1;
    endfunction

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (tx_ready !== 1'b1 && k < 20000) begin
            @(posedge clk); #1;
            k++;
        end
        tests++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s wait_ready: tx_ready=%b after %0d cycles, required 1", name, tx_ready, k);
        end
    endtask

    // Present a byte; returns #1 after the accept edge (first start-bit sample).
    task automatic send(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge clk); #1;
    endtask

    // Watch one frame from n=1 to n=L+1 (first idle cycle) and check it.
    // mode 0: drop valid; 1: keep valid with next_b; 2: alter tx_data after accept;
    // 3: drive valid with 0x3C mid-frame.
    task automatic expect_frame(input logic [7:0] b, input string name, input int mode,
                                input logic [7:0] next_b, output int tail_high);
        int wave_err, ctrl_err, ndone, done_pos, first_bad;
        logic [7:0] dec;
        logic par_s, rdy_end, busy_end;
        wave_err = 0; ctrl_err = 0; ndone = 0; done_pos = -1; first_bad = -1;
        dec = 8'h00; par_s = 1'b0; rdy_end = 1'b0; busy_end = 1'b1; tail_high = 0;
        for (int n = 1; n <= L + 1; n++) begin
            if (n == 1) begin
                if (mode == 1) begin
                    tx_valid = 1'b1;
                    tx_data  = next_b;
                end else begin
                    tx_valid = 1'b0;
                    if (mode == 2) tx_data = ~b;
                end
            end
            if (mode == 3) begin
                if (n == 100) begin
                    tx_valid = 1'b1;
                    tx_data  = 8'h3C;
                end
                if (n == L - 10) tx_valid = 1'b0;
            end
            if (uart_txd !== exp_line(b, n, B)) begin
                wave_err++;
                if (first_bad < 0) first_bad = n;
            end
            if (n > B && n <= 9 * B && ((n - 1) % B) == B / 2) dec[(n-1)/B-1] = uart_txd;
            if (PAR && (n - 1) / B == 9 && ((n - 1) % B) == B / 2) par_s = uart_txd;
            if (tx_done === 1'b1) begin
                ndone++;
                done_pos = n;
            end
            if (n <= L) begin
                if (tx_ready !== 1'b0 || tx_busy !== 1'b1) ctrl_err++;
            end else begin
                rdy_end  = tx_ready;
                busy_end = tx_busy;
            end
            if (uart_txd === 1'b1) tail_high++;
            else tail_high = 0;
            if (n <= L) begin
                @(posedge clk); #1;
            end
        end
        tests++;
        if (wave_err !== 0) begin
            fails++;
            $display("FAIL %s waveform: %0d wrong cycles (first at %0d), required 0", name, wave_err, first_bad);
        end
        tests++;
        if (dec !== b) begin
            fails++;
            $display("FAIL %s decode: got %h, required %h", name, dec, b);
        end
        tests++;
        if (ndone !== 1 || done_pos !== L) begin
            fails++;
            $display("FAIL %s tx_done: %0d pulses at %0d, required 1 at %0d", name, ndone, done_pos, L);
        end
        tests++;
        if (ctrl_err !== 0 || rdy_end !== 1'b1 || busy_end !== 1'b0) begin
            fails++;
            $display("FAIL %s ready/busy: %0d bad in-frame cycles, end ready=%b busy=%b, required 0,1,0",
                     name, ctrl_err, rdy_end, busy_end);
        end
`ifdef UART_TX_PARITY_EN
        tests++;
        if (par_s !== ^b) begin
            fails++;
            $display("FAIL %s parity: got %b, required %b", name, par_s, ^b);
        end
`endif
    endtask

    task automatic test_reset();
        int bad;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (uart_txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: txd=%b ready=%b busy=%b done=%b, required 1,1,0,0",
                     uart_txd, tx_ready, tx_busy, tx_done);
        end
        #2 reset = 1'b1;
        @(posedge clk); #1;
        wait_ready("reset");
        send(8'h00);
        tx_valid = 1'b0;
        // Advance to the middle of data bit 3 (line low for byte 0x00).
        for (int n = 1; n < 4 * B + B / 2; n++) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b0;
        #1;
        tests++;
        if (uart_txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: txd=%b ready=%b busy=%b, required 1,1,0", uart_txd, tx_ready, tx_busy);
        end
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        bad = 0;
        for (int n = 0; n < L + 10; n++) begin
            @(posedge clk); #1;
            if (tx_done !== 1'b0 || uart_txd !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL reset_idle: %0d non-idle cycles after release, required 0", bad);
        end
    endtask

    task automatic test_single(input logic [7:0] b, input string name);
        int tail;
        wait_ready(name);
        send(b);
        expect_frame(b, name, 0, 8'h00, tail);
    endtask

    task automatic test_back_to_back();
        int tail1, tail2;
        wait_ready("b2b");
        send(8'h00);
        expect_frame(8'h00, "b2b_first", 1, 8'hFF, tail1);
        @(posedge clk); #1;
        tests++;
        if (tail1 !== B + 1 || uart_txd !== 1'b0) begin
            fails++;
            $display("FAIL b2b_gap: high run %0d then txd=%b, required %0d then 0", tail1, uart_txd, B + 1);
        end
        expect_frame(8'hFF, "b2b_second", 0, 8'h00, tail2);
    endtask

    task automatic test_handshake();
        int tail;
        wait_ready("hs");
        send(8'h81);
        expect_frame(8'h81, "hs_data_change", 2, 8'h00, tail);
        @(posedge clk); #1;
        wait_ready("hs2");
        send(8'hC5);
        expect_frame(8'hC5, "hs_valid_busy", 3, 8'h00, tail);
    endtask

    task automatic test_small_params();
        logic [7:0] r;
        int k, bad, nd, dpos;
        for (int f = 0; f < 6; f++) begin
            r = 8'($urandom_range(0, 255));
            k = 0;
            while (s_ready !== 1'b1 && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
            s_valid = 1'b1;
            s_data  = r;
            @(posedge clk); #1;
            s_valid = 1'b0;
            s_data  = ~r;
            bad = 0; nd = 0; dpos = -1;
            for (int n = 1; n <= SL + 1; n++) begin
                if (s_txd !== exp_line(r, n, SB)) bad++;
                if (s_done === 1'b1) begin
                    nd++;
                    dpos = n;
                end
                if (n == SL + 1 && (s_ready !== 1'b1 || s_busy !== 1'b0)) bad++;
                if (n <= SL) begin
                    @(posedge clk); #1;
                end
            end
            tests++;
            if (bad !== 0 || nd !== 1 || dpos !== SL) begin
                fails++;
                $display("FAIL small_frame %h: %0d bad cycles, %0d done at %0d, required 0, 1 at %0d",
                         r, bad, nd, dpos, SL);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        test_reset();
        test_single(8'h55, "byte_55");
        test_single(8'hA3, "byte_a3");
        test_back_to_back();
        test_handshake();
        test_single(8'($urandom_range(0, 255)), "byte_random");
`ifdef UART_TX_PARITY_EN
        test_single(8'h07, "parity_07");
        test_single(8'h03, "parity_03");
`endif
        test_small_params();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit-direction counterpart of the block that deserialises `uart_rxd`.
- Accepts one byte per valid/ready handshake and serialises it onto `uart_txd`.
- Frame: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Baud timing derives from a free-running per-bit cycle counter; no oversampling. Sits between the system-side byte source and the board TX pin.

Parameters:
- clk_freq, 50000000, system clock frequency in Hz.
- uart_bps, 115200, line baud rate.
- baud_cnt_max, clk_freq/uart_bps (integer division, 434 at defaults), clock cycles per bit. Must lie in 2..65535.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send; sampled only on the accept cycle.
- tx_valid  input  1  source has a byte on tx_data.
- tx_ready  output  1  block can accept a byte this cycle.
- uart_txd  output  1  serial line, idle high.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, uart_txd=1, tx_ready=1, tx_busy=0, tx_done=0, baud_cnt=0, bit_cnt=0, shift register=0. Any frame in progress is abandoned immediately and the line returns high.
- State machine: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE. All outputs are registered.
- Accept: a handshake occurs on a rising edge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register.
  - Next state is START.
  - On the following cycle uart_txd=0, tx_ready=0, tx_busy=1.
  - tx_valid while tx_ready=0 is ignored; tx_data changes after accept have no effect.
- Bit timing:
  - baud_cnt (16 bit) counts 0..baud_cnt_max-1 in every non-IDLE state, then wraps to 0 and advances the bit.
  - Each bit holds uart_txd for exactly baud_cnt_max cycles.
  - baud_cnt is held at 0 in IDLE.
- DATA:
  - bit_cnt (3 bit) runs 0..7.
  - uart_txd = shift_reg[0]; the register shifts right at each bit boundary.
  - After bit 7 the next state is PARITY if enabled, else STOP.
- STOP:
  - uart_txd=1 for baud_cnt_max cycles.
  - On the final count: tx_done=1 for one cycle, the state returns to IDLE, and on the next cycle tx_ready=1 and tx_busy=0.
- Frame length from the first start-bit cycle to the last stop-bit cycle: 10*baud_cnt_max cycles, or 11*baud_cnt_max with parity. At defaults this is 4340 cycles (4774 with parity).
- Back-to-back: with tx_valid held high, the next byte is accepted in the first IDLE cycle. The line therefore stays high for baud_cnt_max+1 cycles between frames, and no stop bit is ever shortened.
- tx_done and accept may coincide with a new handshake only one cycle later; they never overlap.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - The PARITY state is inserted after data bit 7.
  - uart_txd = even parity, the XOR of the 8 latched data bits, held for baud_cnt_max cycles.
  - Frame is 11 bits.
  - Parity is computed at accept time from tx_data, not from the shifting register.
- Undefined: the PARITY state, parity register and its logic are absent; the frame is 10 bits.

Test Plan:
- Reset: assert reset=0 mid-frame (during data bit 3) -> uart_txd=1, tx_ready=1, tx_busy=0 asynchronously. After release, the block is idle and no tx_done pulse occurs.
- Single byte 0x55 at defaults: accept at cycle T.
  - uart_txd=0 over cycles T+1..T+434.
  - Data bits then alternate 1,0,1,0,... each 434 cycles.
  - Stop bit high.
  - tx_done pulses exactly once at cycle T+4340.
  - tx_ready returns high at T+4341.
- Byte 0xA3, with the bench receiver sampling at mid-bit -> recovers 0xA3 with bit order LSB first (1,1,0,0,0,1,0,1).
- Back-to-back 0x00 then 0xFF with tx_valid held high:
  - The second accept occurs on the first cycle tx_ready=1.
  - The high gap between frames is exactly 435 cycles.
  - Both bytes are decoded correctly.
  - Exactly two tx_done pulses.
- Handshake protection: during a frame, drive tx_valid=1 with tx_data=0x3C -> ignored, and the frame in flight is unchanged. Also change tx_data the cycle after an accept of 0x81 -> 0x81 is transmitted.
- UART_TX_PARITY_EN defined:
  - Send 0x07 -> parity bit 1.
  - Send 0x03 -> parity bit 0.
  - Each frame is 4774 cycles.
  - Small-parameter run with baud_cnt_max=4 (clk_freq=8, uart_bps=2): every bit is exactly 4 cycles wide.
